// File: rtl/sd_sector_server_if.sv
// Sector request/transfer bus plus byte-wide backing-memory port of the sector server.
// The "slave" modport is the server's view; the "master" modport is the requester/memory side.
interface sd_sector_server_if #(
  parameter int SECT_W = 4
);
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic              mem_req;
  logic              mem_we;
  logic [SECT_W+8:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sd_sector_server.sv
// Serves 512-byte sector reads/writes from a byte-wide memory; sd_ack rises one cycle after a request.
// Each byte waits on mem_ack (held mem_req), so memory latency stretches the transfer; out-of-range lbas skip memory.
module sd_sector_server #(
  parameter int SECT_W  = 4,
  parameter int SECTORS = 16,
  parameter int GAP     = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  sd_sector_server_if.slave bus,
  output logic              busy,
  output logic              oor
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_FETCH,
    S_RD_STROBE,
    S_RD_GAP,
    S_WR_ADDR,
    S_WR_WAIT,
    S_WR_SAMPLE,
    S_WR_STORE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SECT_W-1:0] lba_q, lba_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              ack_q, ack_d;
  logic              oor_q, oor_d;

  logic              byte_done;
  state_e            byte_next;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      lba_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      gap_q   <= '0;
      ack_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    gap_d     = gap_q;
    ack_d     = ack_q;
    oor_d     = oor_q;
    byte_done = 1'b0;
    byte_next = S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (bus.sd_rd || bus.sd_wr) begin
          lba_d   = bus.sd_lba[SECT_W-1:0];
          oor_d   = (bus.sd_lba >= 32'(SECTORS));
          cnt_d   = 9'd0;
          ack_d   = 1'b1;
          state_d = bus.sd_rd ? S_RD_FETCH : S_WR_ADDR;
        end
      end
      S_RD_FETCH: begin
        // Out-of-range sectors read as zeros without touching memory.
        if (oor_q) begin
          data_d  = 8'h00;
          state_d = S_RD_STROBE;
        end else if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          state_d = S_RD_STROBE;
        end
      end
      S_RD_STROBE: begin
        if (GAP == 0) begin
          byte_done = 1'b1;
          byte_next = S_RD_FETCH;
        end else begin
          gap_d   = '0;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        if (gap_q == GAP_LAST) begin
          byte_done = 1'b1;
          byte_next = S_RD_FETCH;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_WR_ADDR:   state_d = S_WR_WAIT;
      S_WR_WAIT:   state_d = S_WR_SAMPLE;
      S_WR_SAMPLE: begin
        // The requester's dpram has one cycle of read latency; its data is settled here.
        data_d = bus.sd_buff_din;
        if (oor_q) begin
          byte_done = 1'b1;
          byte_next = S_WR_ADDR;
        end else begin
          state_d = S_WR_STORE;
        end
      end
      S_WR_STORE: begin
        if (bus.mem_ack) begin
          byte_done = 1'b1;
          byte_next = S_WR_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counter stops at 511 so the address holds after the sector ends.
    if (byte_done) begin
      if (cnt_q == 9'd511) begin
        ack_d   = 1'b0;
        state_d = S_DONE;
      end else begin
        cnt_d   = cnt_q + 9'd1;
        state_d = byte_next;
      end
    end
  end

  assign bus.sd_ack       = ack_q;
  assign bus.sd_buff_addr = cnt_q;
  assign bus.sd_buff_dout = data_q;
  assign bus.sd_buff_wr   = (state_q == S_RD_STROBE);
  assign bus.mem_req      = ((state_q == S_RD_FETCH) && !oor_q) || (state_q == S_WR_STORE);
  assign bus.mem_we       = (state_q == S_WR_STORE);
  assign bus.mem_addr     = {lba_q, cnt_q};
  assign bus.mem_wdata    = data_q;
  assign busy             = (state_q != S_IDLE);
  assign oor              = oor_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// Randomized bench for sd_sector_server: memory/dpram models, reference image and a strobe scoreboard.
module tb_sd_sector_server;

  localparam int SECT_W  = 4;
  localparam int SECTORS = 16;
  localparam int GAP     = 2;
  localparam int MEMSZ   = 1 << (SECT_W + 9);

  logic clk_sys;
  logic reset;
  logic busy;
  logic oor;

  sd_sector_server_if #(.SECT_W(SECT_W)) bus ();

  sd_sector_server #(.SECT_W(SECT_W), .SECTORS(SECTORS), .GAP(GAP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .oor     (oor)
  );

  logic [7:0]  mem     [MEMSZ];
  logic [7:0]  ref_img [MEMSZ];
  logic [7:0]  src     [512];
  logic [16:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt = 0, req_cycles = 0, we_cycles = 0;
  int lat_lo = 1, lat_hi = 1;
  bit spur_en = 0;

  int  mon_cyc = 0, mon_last = 0, low_run = 100;
  bit  have_last = 0, prev_ack = 0;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Requester dpram: registered read of the address the server drives.
  always @(posedge clk_sys) bus.sd_buff_din <= src[bus.sd_buff_addr];

  // Backing memory: acks a held request after lat cycles; optional stray acks while idle.
  initial begin
    int lat;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk_sys);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        lat = $urandom_range(lat_hi, lat_lo);
        repeat (lat) @(negedge clk_sys);
        if (bus.mem_req) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_cnt++;
          end else begin
            bus.mem_rdata = mem[bus.mem_addr];
          end
        end
      end else if (spur_en && $urandom_range(3, 0) == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: scoreboard pops on each strobe; also strobe spacing and sd_ack low time.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk_sys);
      mon_cyc++;
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && bus.mem_we) we_cycles++;
      if (bus.sd_buff_wr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: addr=%0d dout=0x%0h, no strobe expected",
                   bus.sd_buff_addr, bus.sd_buff_dout);
        end else begin
          e = exp_q.pop_front();
          check("strobe_addr", 32'(bus.sd_buff_addr), 32'(e[16:8]));
          check("strobe_dout", 32'(bus.sd_buff_dout), 32'(e[7:0]));
        end
        if (have_last) check("strobe_spacing_ok", 32'((mon_cyc - mon_last) >= GAP + 1), 32'd1);
        mon_last  = mon_cyc;
        have_last = 1'b1;
      end
      if (!bus.sd_ack) have_last = 1'b0;
      if (bus.sd_ack && !prev_ack) check("ack_low_2cyc_ok", 32'(low_run >= 2), 32'd1);
      low_run  = bus.sd_ack ? 0 : low_run + 1;
      prev_ack = bus.sd_ack;
    end
  end

  task automatic push_read(input logic [31:0] lba);
    for (int i = 0; i < 512; i++) begin
      if (lba < 32'(SECTORS)) exp_q.push_back({9'(i), ref_img[int'(lba) * 512 + i]});
      else                    exp_q.push_back({9'(i), 8'h00});
    end
  endtask

  // Called right after a falling clock edge; returns at the edge sd_ack is seen high.
  task automatic start_req(input bit rd, input bit wr, input logic [31:0] lba);
    bit was_idle;
    int k;
    was_idle   = !busy;
    bus.sd_lba = lba;
    bus.sd_rd  = rd;
    bus.sd_wr  = wr;
    k = 0;
    while (k < 20) begin
      @(negedge clk_sys);
      k++;
      if (bus.sd_ack) break;
    end
    if (!bus.sd_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: sd_ack=0 after %0d cycles, required 1", k);
      finish_now();
    end
    if (was_idle) check("ack_latency", 32'(k), 32'd1);
    check("oor_at_accept", 32'(oor), 32'(lba >= 32'(SECTORS)));
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (bus.sd_ack && k < 30000) begin
      @(negedge clk_sys);
      k++;
    end
    if (bus.sd_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: sd_ack still 1 after %0d cycles, required 0", k);
      finish_now();
    end
  endtask

  task automatic compare_image(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < MEMSZ; a++) if (mem[a] !== ref_img[a]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] lba, input bit both);
    push_read(lba);
    start_req(1'b1, both, lba);
    wait_done();
    check("strobes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] lba);
    int w0;
    w0 = wr_cnt;
    if (lba < 32'(SECTORS))
      for (int i = 0; i < 512; i++) ref_img[int'(lba) * 512 + i] = src[i];
    start_req(1'b0, 1'b1, lba);
    wait_done();
    check("write_count", 32'(wr_cnt - w0), (lba < 32'(SECTORS)) ? 32'd512 : 32'd0);
    compare_image("mem_image_after_write");
  endtask

  initial begin
    int r0, w0, k, lba;
    reset      = 1'b1;
    bus.sd_lba = '0;
    bus.sd_rd  = 1'b0;
    bus.sd_wr  = 1'b0;
    for (int a = 0; a < MEMSZ; a++) begin
      mem[a]     = 8'(a) ^ 8'h5A;
      ref_img[a] = 8'(a) ^ 8'h5A;
    end
    for (int i = 0; i < 512; i++) src[i] = 8'h00;
    repeat (3) @(negedge clk_sys);

    check("rst_sd_ack", 32'(bus.sd_ack), 32'd0);
    check("rst_buff_wr", 32'(bus.sd_buff_wr), 32'd0);
    check("rst_buff_addr", 32'(bus.sd_buff_addr), 32'd0);
    check("rst_buff_dout", 32'(bus.sd_buff_dout), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oor", 32'(oor), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Plain read, one-cycle memory.
    do_read(32'd3, 1'b0);
    @(negedge clk_sys);
    check("busy_after_read", 32'(busy), 32'd0);

    // Write with random memory latency.
    spur_en = 1'b1;
    lat_lo  = 1;
    lat_hi  = 7;
    for (int i = 0; i < 512; i++) src[i] = ~8'(i);
    do_write(32'd5);

    // Out-of-range read and write, then a valid read clears oor.
    lat_hi = 3;
    r0 = req_cycles;
    do_read(32'd16, 1'b0);
    check("oor_rd_no_mem_req", 32'(req_cycles - r0), 32'd0);
    check("oor_sticky", 32'(oor), 32'd1);
    for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
    r0 = req_cycles;
    do_write(32'h100);
    check("oor_wr_no_mem_req", 32'(req_cycles - r0), 32'd0);
    do_read(32'd2, 1'b0);
    check("oor_cleared", 32'(oor), 32'd0);

    // Read and write raised together: read wins.
    w0 = we_cycles;
    do_read(32'd9, 1'b1);
    check("both_no_mem_we", 32'(we_cycles - w0), 32'd0);
    compare_image("mem_image_after_both");

    // Back-to-back load of all sectors, re-raising at each sd_ack fall.
    lat_hi = 1;
    for (int l = 0; l < SECTORS; l++) do_read(32'(l), 1'b0);
    @(negedge clk_sys);
    check("busy_after_b2b", 32'(busy), 32'd0);
    compare_image("mem_image_after_b2b");

    // Reset in the middle of a write, then a clean read of the same sector.
    lat_hi = 4;
    for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
    w0 = wr_cnt;
    start_req(1'b0, 1'b1, 32'd7);
    k = 0;
    while (bus.sd_buff_addr != 9'd200 && k < 6000) begin
      @(negedge clk_sys);
      k++;
    end
    if (bus.sd_buff_addr != 9'd200) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte200_timeout: sd_buff_addr=%0d, required 200", bus.sd_buff_addr);
      finish_now();
    end
    reset = 1'b1;
    @(negedge clk_sys);
    check("midrst_sd_ack", 32'(bus.sd_ack), 32'd0);
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) ref_img[7 * 512 + i] = src[i];
    repeat (2) @(negedge clk_sys);
    check("midrst_write_count", 32'(wr_cnt - w0), 32'd200);
    compare_image("mem_image_after_midrst");
    do_read(32'd7, 1'b0);

    // A couple of random transfers.
    lat_hi = 5;
    for (int t = 0; t < 2; t++) begin
      lba = $urandom_range(SECTORS + 3, 0);
      if ($urandom_range(1, 0) == 1) begin
        do_read(32'(lba), 1'b0);
      end else begin
        for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
        do_write(32'(lba));
      end
    end

    repeat (3) @(negedge clk_sys);
    compare_image("mem_image_final");
    finish_now();
  end

endmodule

// File: doc/sd_sector_server.md
Name: sd_sector_server

Overview:
- Responder (host) side of the core's sector interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) used by the save-RAM backup logic.
- Services 512-byte sector read and write requests against a byte-wide backing memory with variable latency, e.g. a RAM-disk for save images or the simulation model of the SD host.
- Sits between the backup state machine / nvram dpram and an SDRAM or BRAM byte port.

Parameters:
SECT_W, 4, sector-index bits; backing memory holds 2^SECT_W sectors.
SECTORS, 16, number of valid sectors; lba >= SECTORS is out of range.
GAP, 2, idle cycles inserted after each sd_buff_wr strobe (min 0).

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
sd_lba  in  32  sector number, sampled at request acceptance
sd_rd  in  1  read request, level
sd_wr  in  1  write request, level
sd_ack  out  1  high for the whole sector transfer
sd_buff_addr  out  9  byte index within sector
sd_buff_dout  out  8  read data to requester
sd_buff_wr  out  1  one-cycle strobe, sd_buff_dout valid at sd_buff_addr
sd_buff_din  in  8  write data from requester dpram; 1-cycle read latency
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req is high
mem_addr  out  SECT_W+9  {lba[SECT_W-1:0], byte index}
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid in mem_ack cycle
mem_ack  in  1  one-cycle completion pulse
busy  out  1  state != IDLE
oor  out  1  sticky: last accepted lba was out of range; cleared at next acceptance

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0. Reset mid-transfer abandons the sector and drops mem_req the next cycle; the backing memory must tolerate an abandoned request.
- IDLE:
  - sd_rd|sd_wr high -> latch lba and direction (sd_rd wins if both high), set oor = (lba >= SECTORS), counter = 0.
  - Raise sd_ack on the next cycle; it stays high until the last byte completes.
- mem_ack while no mem_req is outstanding is ignored.
- READ (per byte i = 0..511):
  - FETCH: mem_req=1, mem_we=0, mem_addr={lba,i}; wait for mem_ack; capture mem_rdata.
    - If oor: no mem_req; data = 0x00, one cycle.
  - STROBE: sd_buff_addr=i, sd_buff_dout=data, sd_buff_wr=1 for exactly one cycle.
  - GAP: GAP cycles with sd_buff_wr=0, then i+1.
- WRITE (per byte i):
  - ADDR: sd_buff_addr=i, held.
  - WAIT: one cycle.
  - SAMPLE: capture sd_buff_din, i.e. the second cycle after the address is driven.
  - STORE: mem_req=1, mem_we=1, mem_wdata=captured; wait for mem_ack.
    - If oor: skip the store; data is discarded.
- DONE: after byte 511, deassert sd_ack and return to IDLE.
  - sd_ack stays low at least 2 cycles before the next rise.
  - A request held or re-raised at the falling edge of sd_ack is accepted normally.
- sd_buff_wr is never asserted during writes. sd_buff_addr holds its last value outside transfers.
- Byte counter is 9 bits; completion is detected at 511, with no wrap into a 513th byte.
- Requester drops sd_rd/sd_wr at the rising edge of sd_ack. Level changes after acceptance are ignored until DONE.
- Only lba[SECT_W-1:0] drives mem_addr; the out-of-range check uses all 32 bits.

Test Plan:
- Read, lba=3, memory preloaded with byte = (addr[7:0]^0x5A), mem_ack 1 cycle after mem_req -> sd_ack high one cycle after sd_rd; 512 sd_buff_wr strobes with addr 0..511 and dout = ({3,i}[7:0]^0x5A); strobes spaced ≥ GAP+1 cycles; then sd_ack falls, busy=0.
- Write, lba=5, requester dpram holds byte i = ~i[7:0], mem_ack random 1–7 cycles -> memory sectors 5 bytes 0..511 = ~i; no sd_buff_wr pulses; other sectors unchanged.
- Back-to-back: 16-sector load loop re-raising sd_rd on each ack fall (lba 0..15) -> 16 transfers, sd_ack low ≥2 cycles between them, final memory image matches.
- lba=16 (SECTORS=16) read -> oor=1, no mem_req, 512 strobes of 0x00; write to lba=0x100 -> oor=1, no mem writes. Next valid request clears oor.
- sd_rd and sd_wr raised in the same cycle -> read performed, no mem_we=1 observed.
- Reset asserted at byte 200 of a write -> next cycle sd_ack=0, mem_req=0, busy=0; a fresh read then completes normally from byte 0.
